gfp8_dot_sequencer: RTL and testbench

- Sequences a multi-group GFP8 dot product through the existing 32-pair group-dot datapath, which has a fixed pipeline latency.
- Accepts a command giving the group count, then streams group operand pairs into the datapath over a valid/ready handshake.
- Accumulates the returned per-group results into one block result, aligning exponents as it goes.
- Sits between the operand-fetch logic and the result writeback path in the GEMM engine.

---
 rtl/gfp8_pkg.sv | 18 +
 rtl/gfp8_align_acc.sv | 76 +++++++
 rtl/gfp8_dot_sequencer.sv | 110 +++++++++++
 tb/tb_gfp8_dot_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfp8_pkg.sv
// Shared GFP8 definitions: group geometry, exponent bias, exponent type and
// the dot-sequencer FSM state encoding.
package gfp8_pkg;

  localparam int unsigned GFP_GROUP_SIZE = 32;
  localparam int unsigned GFP_INT_SIZE   = 8;
  localparam int unsigned GFP_BIAS       = 15;

  typedef logic signed [7:0] gfp_exp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/gfp8_align_acc.sv
// Registered align-and-add of per-group dot results into a block accumulator.
// Optional GFP8_SEQ_ZERO_SKIP_EN: zero mantissas leave the accumulator untouched.
module gfp8_align_acc
  import gfp8_pkg::*;
#(
  parameter int unsigned ACC_W = 48
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_clear,
  input  logic                    i_valid,
  input  logic signed [31:0]      i_mantissa,
  input  gfp_exp_t                i_exponent,
  output logic signed [ACC_W-1:0] o_acc,
  output gfp_exp_t                o_acc_exp
);

  localparam int unsigned SH_W = $clog2(ACC_W);

  logic                    first_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] m_ext;
  gfp_exp_t                exp_q;
  gfp_exp_t                exp_d;
  logic signed [8:0]       diff;
  logic [8:0]              mag;
  logic [SH_W-1:0]         sh;
  logic                    exp_gt;
  logic                    take;

  always_comb begin
    m_ext  = ACC_W'(i_mantissa);
    diff   = 9'(i_exponent) - 9'(exp_q);
    mag    = diff[8] ? 9'(-diff) : 9'(diff);
    // Shifts beyond ACC_W-1 would only repeat the sign bit, so clamp there.
    sh     = (mag > 9'(ACC_W - 1)) ? SH_W'(ACC_W - 1) : SH_W'(mag);
    exp_gt = diff > 9'sd0;
`ifdef GFP8_SEQ_ZERO_SKIP_EN
    take   = i_valid && (i_mantissa != '0);
`else
    take   = i_valid;
`endif
    acc_d  = acc_q;
    exp_d  = exp_q;
    if (first_q) begin
      acc_d = m_ext;
      exp_d = i_exponent;
    end else if (exp_gt) begin
      acc_d = (acc_q >>> sh) + m_ext;
      exp_d = i_exponent;
    end else begin
      acc_d = acc_q + (m_ext >>> sh);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      first_q <= 1'b0;
      acc_q   <= '0;
      exp_q   <= '0;
    end else if (i_clear) begin
      first_q <= 1'b1;
      acc_q   <= '0;
      exp_q   <= '0;
    end else if (take) begin
      first_q <= 1'b0;
      acc_q   <= acc_d;
      exp_q   <= exp_d;
    end
  end

  assign o_acc     = acc_q;
  assign o_acc_exp = exp_q;

endmodule

// File: rtl/gfp8_dot_sequencer.sv
// Streams a command's GFP8 groups through the fixed-latency group-dot datapath
// and folds the returned results into one block result (see GFP8_SEQ_ZERO_SKIP_EN).
module gfp8_dot_sequencer
  import gfp8_pkg::*;
#(
  parameter int unsigned MAX_GROUPS  = 128,
  parameter int unsigned CNT_W       = $clog2(MAX_GROUPS + 1),
  parameter int unsigned DOT_LATENCY = 1,
  parameter int unsigned ACC_W       = 48
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset_n,
  input  logic                                   i_cmd_valid,
  output logic                                   o_cmd_ready,
  input  logic [CNT_W-1:0]                       i_cmd_num_groups,
  input  logic                                   i_grp_valid,
  output logic                                   o_grp_ready,
  input  logic [7:0]                             i_grp_exp_left,
  input  logic [7:0]                             i_grp_exp_right,
  input  logic [GFP_GROUP_SIZE*GFP_INT_SIZE-1:0] i_grp_man_left,
  input  logic [GFP_GROUP_SIZE*GFP_INT_SIZE-1:0] i_grp_man_right,
  output logic [7:0]                             o_dot_exp_left,
  output logic [7:0]                             o_dot_exp_right,
  output logic [GFP_GROUP_SIZE*GFP_INT_SIZE-1:0] o_dot_man_left,
  output logic [GFP_GROUP_SIZE*GFP_INT_SIZE-1:0] o_dot_man_right,
  output logic                                   o_dot_issue,
  input  logic signed [31:0]                     i_dot_mantissa,
  input  gfp_exp_t                               i_dot_exponent,
  output logic                                   o_res_valid,
  input  logic                                   i_res_ready,
  output logic signed [ACC_W-1:0]                o_res_mantissa,
  output gfp_exp_t                               o_res_exponent,
  output logic                                   o_busy
);

  seq_state_t             state_q;
  seq_state_t             state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       n_clamp;
  logic [DOT_LATENCY-1:0] dl_q;
  logic [DOT_LATENCY-1:0] dl_d;
  logic                   accept;
  logic                   grp_hs;

  assign n_clamp = (i_cmd_num_groups > CNT_W'(MAX_GROUPS)) ? CNT_W'(MAX_GROUPS)
                                                           : i_cmd_num_groups;
  assign accept  = i_cmd_valid & o_cmd_ready;
  assign grp_hs  = i_grp_valid & o_grp_ready;
  // Delay line mirrors the datapath pipeline; its MSB marks a result arriving now.
  assign dl_d    = DOT_LATENCY'({dl_q, grp_hs});

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dl_q    <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= dl_d;
      if (accept) begin
        cnt_q <= n_clamp;
      end else if (grp_hs) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_cmd_valid) state_d = (n_clamp == '0) ? DONE : ISSUE;
      ISSUE:   if (grp_hs && cnt_q == CNT_W'(1)) state_d = DRAIN;
      DRAIN:   if (dl_d == '0) state_d = DONE;
      DONE:    if (i_res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready     = 1'b0;
    o_grp_ready     = 1'b0;
    o_res_valid     = 1'b0;
    unique case (state_q)
      IDLE:    o_cmd_ready = 1'b1;
      ISSUE:   o_grp_ready = 1'b1;
      DONE:    o_res_valid = 1'b1;
      default: ;
    endcase
    o_busy          = state_q != IDLE;
    o_dot_issue     = grp_hs;
    o_dot_exp_left  = o_grp_ready ? i_grp_exp_left  : '0;
    o_dot_exp_right = o_grp_ready ? i_grp_exp_right : '0;
    o_dot_man_left  = o_grp_ready ? i_grp_man_left  : '0;
    o_dot_man_right = o_grp_ready ? i_grp_man_right : '0;
  end

  gfp8_align_acc #(
    .ACC_W(ACC_W)
  ) u_align_acc (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_clear    (accept),
    .i_valid    (dl_q[DOT_LATENCY-1]),
    .i_mantissa (i_dot_mantissa),
    .i_exponent (i_dot_exponent),
    .o_acc      (o_res_mantissa),
    .o_acc_exp  (o_res_exponent)
  );

endmodule

// File: tb/tb_gfp8_dot_sequencer.sv
// Bench for gfp8_dot_sequencer: table vectors, hand-written corner sequences and
// randomized commands checked against a folding reference model.
module tb_gfp8_dot_sequencer;
  import gfp8_pkg::*;

  localparam int MAXG = 128;
  localparam int LAT  = 1;
  localparam int ACCW = 48;
  localparam int CW   = $clog2(MAXG + 1);

  logic               i_clk = 1'b0;
  logic               i_reset_n;
  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic [CW-1:0]      i_cmd_num_groups;
  logic               i_grp_valid;
  logic               o_grp_ready;
  logic [7:0]         i_grp_exp_left, i_grp_exp_right;
  logic [255:0]       i_grp_man_left, i_grp_man_right;
  logic [7:0]         o_dot_exp_left, o_dot_exp_right;
  logic [255:0]       o_dot_man_left, o_dot_man_right;
  logic               o_dot_issue;
  logic signed [31:0] i_dot_mantissa;
  logic signed [7:0]  i_dot_exponent;
  logic               o_res_valid;
  logic               i_res_ready;
  logic signed [ACCW-1:0] o_res_mantissa;
  logic signed [7:0]  o_res_exponent;
  logic               o_busy;

  int nchk = 0;
  int nerr = 0;

  byte        g_ml [MAXG][32];
  byte        g_mr [MAXG][32];
  logic [7:0] g_el [MAXG];
  logic [7:0] g_er [MAXG];

  gfp8_dot_sequencer #(
    .MAX_GROUPS (MAXG),
    .DOT_LATENCY(LAT),
    .ACC_W      (ACCW)
  ) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .i_cmd_num_groups (i_cmd_num_groups),
    .i_grp_valid      (i_grp_valid),
    .o_grp_ready      (o_grp_ready),
    .i_grp_exp_left   (i_grp_exp_left),
    .i_grp_exp_right  (i_grp_exp_right),
    .i_grp_man_left   (i_grp_man_left),
    .i_grp_man_right  (i_grp_man_right),
    .o_dot_exp_left   (o_dot_exp_left),
    .o_dot_exp_right  (o_dot_exp_right),
    .o_dot_man_left   (o_dot_man_left),
    .o_dot_man_right  (o_dot_man_right),
    .o_dot_issue      (o_dot_issue),
    .i_dot_mantissa   (i_dot_mantissa),
    .i_dot_exponent   (i_dot_exponent),
    .o_res_valid      (o_res_valid),
    .i_res_ready      (i_res_ready),
    .o_res_mantissa   (o_res_mantissa),
    .o_res_exponent   (o_res_exponent),
    .o_busy           (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Group-dot datapath stand-in: LAT register stages of sum(l*r), el+er-2*bias.
  int                pm [LAT];
  logic signed [7:0] pe [LAT];
  always @(posedge i_clk) begin
    int s;
    s = 0;
    for (int k = 0; k < 32; k++)
      s = s + $signed(o_dot_man_left[8*k +: 8]) * $signed(o_dot_man_right[8*k +: 8]);
    pm[0] <= s;
    pe[0] <= o_dot_exp_left + o_dot_exp_right - 8'(2 * GFP_BIAS);
    for (int j = 1; j < LAT; j++) begin
      pm[j] <= pm[j-1];
      pe[j] <= pe[j-1];
    end
  end
  assign i_dot_mantissa = pm[LAT-1];
  assign i_dot_exponent = pe[LAT-1];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint gdot(input int i);
    longint s = 0;
    for (int k = 0; k < 32; k++) s += longint'(g_ml[i][k]) * longint'(g_mr[i][k]);
    return s;
  endfunction

  function automatic int gexp(input int i);
    return int'(g_el[i]) + int'(g_er[i]) - 2 * int'(GFP_BIAS);
  endfunction

  // Division by 2^d rounded toward minus infinity.
  function automatic longint fshift(input longint x, input int d);
    longint p = longint'(1) << d;
    if (x >= 0) return x / p;
    return -((-x + p - 1) / p);
  endfunction

  function automatic void ref_model(input int n, output longint rm, output int re);
    longint acc = 0;
    int     ae  = 0;
    bit     first = 1'b1;
    for (int i = 0; i < n; i++) begin
      longint m = gdot(i);
      int     e = gexp(i);
      int     d = (e > ae) ? e - ae : ae - e;
`ifdef GFP8_SEQ_ZERO_SKIP_EN
      if (m == 0) continue;
`endif
      if (d > ACCW - 1) d = ACCW - 1;
      if (first) begin
        acc = m; ae = e; first = 1'b0;
      end else if (e > ae) begin
        acc = fshift(acc, d) + m; ae = e;
      end else begin
        acc = acc + fshift(m, d);
      end
    end
    rm = acc;
    re = ae;
  endfunction

  task automatic set_uniform(input int i, input int ml, input int mr, input int el, input int er);
    for (int k = 0; k < 32; k++) begin
      g_ml[i][k] = byte'(ml);
      g_mr[i][k] = byte'(mr);
    end
    g_el[i] = 8'(el);
    g_er[i] = 8'(er);
  endtask

  task automatic set_random(input int i, input bit zero);
    for (int k = 0; k < 32; k++) begin
      g_ml[i][k] = zero ? 8'sd0 : byte'($urandom_range(0, 255));
      g_mr[i][k] = byte'($urandom_range(0, 255));
    end
    g_el[i] = 8'($urandom_range(8, 28));
    g_er[i] = 8'($urandom_range(8, 28));
  endtask

  task automatic drive_grp(input int i);
    for (int k = 0; k < 32; k++) begin
      i_grp_man_left[8*k +: 8]  = g_ml[i][k];
      i_grp_man_right[8*k +: 8] = g_mr[i][k];
    end
    i_grp_exp_left  = g_el[i];
    i_grp_exp_right = g_er[i];
  endtask

  task automatic send_cmd(input int n);
    int w = 0;
    i_cmd_valid      = 1'b1;
    i_cmd_num_groups = CW'(n);
    @(negedge i_clk);
    while (!o_cmd_ready && w < 50) begin
      @(negedge i_clk);
      w++;
    end
    check("cmd_ready_idle", o_cmd_ready, 1);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random bubbles
  task automatic feed(input int cnt, input int mode);
    int i = 0;
    int cyc = 0;
    bit v, r;
    while (i < cnt && cyc < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = $urandom_range(0, 2) != 0;
      endcase
      i_grp_valid = v;
      drive_grp(i);
      @(negedge i_clk);
      r = o_grp_ready;
      check("dot_issue", o_dot_issue, v & r);
      @(posedge i_clk); #1;
      if (v && r) i++;
      cyc++;
    end
    i_grp_valid = 1'b0;
    check("feed_count", i, cnt);
  endtask

  task automatic await_result(output int lat);
    lat = 0;
    @(negedge i_clk);
    while (!o_res_valid && lat < 500) begin
      lat++;
      @(negedge i_clk);
    end
    check("res_valid", o_res_valid, 1);
  endtask

  task automatic check_result(input int hold, input longint em, input int ee);
    check("res_man", o_res_mantissa, em);
    check("res_exp", o_res_exponent, ee);
    check("cmd_ready_done", o_cmd_ready, 0);
    check("busy_done", o_busy, 1);
    repeat (hold) begin
      @(negedge i_clk);
      check("hold_valid", o_res_valid, 1);
      check("hold_man", o_res_mantissa, em);
      check("hold_exp", o_res_exponent, ee);
      check("hold_cmd_ready", o_cmd_ready, 0);
    end
    i_res_ready = 1'b1;
    @(posedge i_clk); #1;
    i_res_ready = 1'b0;
    @(negedge i_clk);
    check("post_cmd_ready", o_cmd_ready, 1);
    check("post_res_valid", o_res_valid, 0);
    @(posedge i_clk); #1;
  endtask

  typedef struct {
    int     n;
    int     ml0, mr0, el0, er0;
    int     ml1, mr1, el1, er1;
    longint em;
    int     ee;
  } vec_t;

  vec_t   tbl[9];
  longint em;
  int     ee, lat, n, mode, hold, hs, cyc;

  initial begin
    tbl[0] = '{2,  1, 1, 15, 15,   2, 1, 16, 15,   80, 1};
    tbl[1] = '{2, -1, 1, 15, 15,   1, 1, 20, 15,   31, 5};
    tbl[2] = '{1,  3, -2, 15, 17,  0, 0, 15, 15, -192, 2};
    tbl[3] = '{2,  1, 1, 20, 15,   1, 1, 15, 15,   33, 5};
    tbl[4] = '{2, -1, 1, 15, 15,   1, 1, 15, 15,    0, 0};
    tbl[5] = '{2,  1, 1, 15, 15,   1, 1, 100, 15,  32, 85};
    tbl[6] = '{2, -1, 1, 15, 15,   1, 1, 100, 15,  31, 85};
`ifdef GFP8_SEQ_ZERO_SKIP_EN
    tbl[7] = '{2,  1, 1, 15, 15,   0, 1, 40, 15,   32, 0};
    tbl[8] = '{2,  0, 0, 60, 15,   1, 1, 15, 15,   32, 0};
`else
    tbl[7] = '{2,  1, 1, 15, 15,   0, 1, 40, 15,    0, 25};
    tbl[8] = '{2,  0, 0, 60, 15,   1, 1, 15, 15,    0, 45};
`endif

    i_reset_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_num_groups = '0;
    i_grp_valid = 1'b0; i_res_ready = 1'b0;
    i_grp_exp_left = '0; i_grp_exp_right = '0;
    i_grp_man_left = '0; i_grp_man_right = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_cmd_ready", o_cmd_ready, 1);
    check("rst_grp_ready", o_grp_ready, 0);
    check("rst_res_valid", o_res_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_dot_issue", o_dot_issue, 0);
    check("rst_res_man", o_res_mantissa, 0);
    check("rst_res_exp", o_res_exponent, 0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    for (int t = 0; t < 9; t++) begin
      set_uniform(0, tbl[t].ml0, tbl[t].mr0, tbl[t].el0, tbl[t].er0);
      set_uniform(1, tbl[t].ml1, tbl[t].mr1, tbl[t].el1, tbl[t].er1);
      send_cmd(tbl[t].n);
      feed(tbl[t].n, 0);
      await_result(lat);
      check("tbl_latency", lat, LAT);
      check_result(0, tbl[t].em, tbl[t].ee);
    end

    // Zero-length command: straight to DONE, no group ever requested.
    send_cmd(0);
    check("n0_grp_ready", o_grp_ready, 0);
    await_result(lat);
    check("n0_latency", lat, 0);
    check_result(1, 0, 0);

    // Bubbles every other cycle plus a held-off result consumer.
    for (int g = 0; g < 4; g++) set_random(g, 1'b0);
    ref_model(4, em, ee);
    send_cmd(4);
    feed(4, 1);
    await_result(lat);
    check("bp_latency", lat, LAT);
    check_result(5, em, ee);

    // Oversized request is clamped to MAXG groups.
    for (int g = 0; g < MAXG; g++) set_random(g, $urandom_range(0, 7) == 0);
    ref_model(MAXG, em, ee);
    send_cmd(200);
    i_grp_valid = 1'b1;
    hs = 0; cyc = 0;
    drive_grp(0);
    @(negedge i_clk);
    while (o_grp_ready && cyc < 300) begin
      @(posedge i_clk); #1;
      hs++; cyc++;
      drive_grp(hs % MAXG);
      @(negedge i_clk);
    end
    i_grp_valid = 1'b0;
    check("clamp_count", hs, MAXG);
    check("clamp_busy", o_busy, 1);
    await_result(lat);
    check_result(0, em, ee);

    // Reset in the middle of ISSUE, then a clean single-group command.
    for (int g = 0; g < 5; g++) set_random(g, 1'b0);
    send_cmd(5);
    feed(3, 0);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    check("mid_rst_cmd_ready", o_cmd_ready, 1);
    check("mid_rst_grp_ready", o_grp_ready, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_res_valid", o_res_valid, 0);
    check("mid_rst_res_man", o_res_mantissa, 0);
    check("mid_rst_res_exp", o_res_exponent, 0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    set_uniform(0, 1, 1, 15, 15);
    send_cmd(1);
    feed(1, 0);
    await_result(lat);
    check("post_rst_latency", lat, LAT);
    check_result(0, 32, 0);

    for (int t = 0; t < 20; t++) begin
      n    = $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      hold = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) set_random(g, $urandom_range(0, 4) == 0);
      ref_model(n, em, ee);
      send_cmd(n);
      feed(n, mode);
      await_result(lat);
      check("rand_latency", lat, LAT);
      check_result(hold, em, ee);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
